sonar_varredura_uc_fd: RTL and testbench

//   Parametrised sweep sequencer for the sonar: steps the servo over N_POS positions (bounce, 0..N-1..0),

---
 rtl/sonar_varredura_uc_fd.sv | 153 +++++++++++++++
 tb/tb_sonar_varredura_uc_fd.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sonar_varredura_uc_fd.sv
// Sonar sweep sequencer: settle, measure with echo timeout, transmit, then bounce the servo position.
// Optional running-minimum tracking is compiled in with SONAR_MINIMO_EN.
module sonar_varredura_uc_fd #(
  parameter int N_POS          = 8,
  parameter int POS_W          = 3,
  parameter int SETTLE_CYCLES  = 50000000,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int MEAS_W         = 12
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              ligar_i,
  input  logic              eco_pronto_i,
  input  logic [MEAS_W-1:0] eco_medida_i,
  input  logic              tx_pronto_i,
  output logic              medir_o,
  output logic              tx_inicio_o,
  output logic [MEAS_W-1:0] tx_medida_o,
  output logic [POS_W-1:0]  posicao_o,
  output logic              timeout_o,
  output logic              fim_varredura_o,
`ifdef SONAR_MINIMO_EN
  output logic [MEAS_W-1:0] min_medida_o,
  output logic [POS_W-1:0]  min_posicao_o,
`endif
  output logic [3:0]        db_estado_o
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(N_POS - 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, GIRO = 4'd1, MEDE = 4'd2, ESPERA = 4'd3,
    TRANSMITE = 4'd4, ESPERA_TX = 4'd5, PROXIMO = 4'd6
  } estado_t;

  estado_t           state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d, pos_step;
  logic              up_q, up_d;
  logic [MEAS_W-1:0] txm_q, txm_d;
  logic              to_q, to_d;
  logic              fim_q, fim_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      up_q    <= 1'b1;
      txm_q   <= '0;
      to_q    <= 1'b0;
      fim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      up_q    <= up_d;
      txm_q   <= txm_d;
      to_q    <= to_d;
      fim_q   <= fim_d;
    end
  end

  assign pos_step = up_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

  // The shared counter is zero on entry to GIRO and ESPERA because every other state clears it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pos_d       = pos_q;
    up_d        = up_q;
    txm_d       = txm_q;
    to_d        = to_q;
    fim_d       = 1'b0;
    medir_o     = 1'b0;
    tx_inicio_o = 1'b0;
    case (state_q)
      IDLE: if (ligar_i) state_d = GIRO;
      GIRO: begin
        if (!ligar_i)                 state_d = IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = MEDE;
        else                           cnt_d = cnt_q + CNT_W'(1);
      end
      MEDE: begin
        medir_o = 1'b1;
        state_d = ESPERA;
      end
      ESPERA: begin
        if (eco_pronto_i) begin
          txm_d   = eco_medida_i;
          to_d    = 1'b0;
          state_d = TRANSMITE;
        end else if (cnt_q == TOUT_LAST) begin
          txm_d   = '1;
          to_d    = 1'b1;
          state_d = TRANSMITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TRANSMITE: begin
        tx_inicio_o = 1'b1;
        state_d     = ESPERA_TX;
      end
      ESPERA_TX: if (tx_pronto_i) state_d = PROXIMO;
      PROXIMO: begin
        pos_d = pos_step;
        if (pos_step == POS_LAST) begin
          up_d  = 1'b0;
          fim_d = 1'b1;
        end
        if (pos_step == '0) begin
          up_d  = 1'b1;
          fim_d = 1'b1;
        end
        state_d = ligar_i ? GIRO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_medida_o     = txm_q;
  assign posicao_o       = pos_q;
  assign timeout_o       = to_q;
  assign fim_varredura_o = fim_q;
  assign db_estado_o     = state_q;

`ifdef SONAR_MINIMO_EN
  logic [MEAS_W-1:0] min_q;
  logic [POS_W-1:0]  minpos_q;

  // Strict less-than keeps the first position on ties; packed BCD orders like binary.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      min_q    <= '1;
      minpos_q <= '0;
    end else if (fim_q) begin
      min_q    <= '1;
    end else if (state_q == ESPERA && eco_pronto_i && eco_medida_i < min_q) begin
      min_q    <= eco_medida_i;
      minpos_q <= pos_q;
    end
  end

  assign min_medida_o  = min_q;
  assign min_posicao_o = minpos_q;
`endif

endmodule

// File: tb/tb_sonar_varredura_uc_fd.sv
// Directed bench for the sonar sweep sequencer: driver issues frames and queues the expected
// frame contents; a negedge monitor checks every tx_inicio and fim_varredura pulse against the queues.
module tb_sonar_varredura_uc_fd;
  localparam int N_POS = 4, POS_W = 2, SETTLE = 10, TOUT = 20, MW = 12;

  logic clk = 1'b0;
  logic rst, ligar, eco, txp;
  logic [MW-1:0] eco_med;
  logic medir, tx_inicio, timeout, fim;
  logic [MW-1:0] tx_medida;
  logic [POS_W-1:0] posicao;
  logic [3:0] estado;

  sonar_varredura_uc_fd #(
    .N_POS(N_POS), .POS_W(POS_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TOUT), .MEAS_W(MW)
  ) dut (
    .clock_i(clk), .reset_i(rst), .ligar_i(ligar), .eco_pronto_i(eco), .eco_medida_i(eco_med),
    .tx_pronto_i(txp), .medir_o(medir), .tx_inicio_o(tx_inicio), .tx_medida_o(tx_medida),
    .posicao_o(posicao), .timeout_o(timeout), .fim_varredura_o(fim), .db_estado_o(estado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MW-1:0]    med;
    logic             to;
    logic [POS_W-1:0] pos;
  } exp_t;

  int checks = 0, failures = 0, medir_cnt = 0;
  exp_t txq[$];
  logic [POS_W-1:0] fimq[$];
  logic [MW-1:0] cur_med = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event-missing expected event", name);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (medir) medir_cnt++;
      if (tx_inicio) begin
        if (txq.size() == 0) fail_now("tx_unexpected");
        else begin
          e = txq.pop_front();
          chk("tx_medida", tx_medida, e.med);
          chk("timeout", timeout, e.to);
          chk("tx_posicao", posicao, e.pos);
          cur_med = e.med;
        end
      end
      if (txp) chk("tx_medida_stable", tx_medida, cur_med);
      if (fim) begin
        if (fimq.size() == 0) fail_now("fim_unexpected");
        else chk("fim_posicao", posicao, fimq.pop_front());
      end
    end
  end

  // dly=0 means no echo at all; otherwise echo pulses dly cycles after the medir cycle.
  task automatic frame(input int dly, input logic [MW-1:0] val, input logic [MW-1:0] expm,
                       input logic expto, input logic [POS_W-1:0] pos, input bit drop_ligar);
    int n;
    txq.push_back('{med: expm, to: expto, pos: pos});
    n = 0;
    while (!medir && n < 200) begin @(posedge clk); #1; n++; end
    if (!medir) fail_now("medir_wait");
    if (dly > 0) begin
      repeat (dly) @(posedge clk);
      #1; eco = 1'b1; eco_med = val;
      @(posedge clk); #1; eco = 1'b0;
    end
    n = 0;
    while (!tx_inicio && n < 200) begin @(posedge clk); #1; n++; end
    if (!tx_inicio) fail_now("tx_inicio_wait");
    if (drop_ligar) ligar = 1'b0;
    @(posedge clk); #1;
    eco = 1'b1; eco_med = 12'hABC;
    @(posedge clk); #1; eco = 1'b0;
    @(posedge clk); #1; txp = 1'b1;
    @(posedge clk); #1; txp = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, mc;
    rst = 1'b1; ligar = 1'b0; eco = 1'b0; txp = 1'b0; eco_med = '0;
    fimq.push_back(2'd3); fimq.push_back(2'd0); fimq.push_back(2'd3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_estado", estado, 0);
    chk("rst_posicao", posicao, 0);
    chk("rst_tx_medida", tx_medida, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_pulses", {medir, tx_inicio, fim}, 0);

    @(posedge clk); #1 ligar = 1'b1;
    n = 0;
    while (!medir && n < 100) begin @(posedge clk); #1; n++; end
    chk("medir_latency", n, 11);
    chk("first_posicao", posicao, 0);

    frame(5,  12'h123, 12'h123, 1'b0, 2'd0, 1'b0);
    frame(0,  12'h000, 12'hFFF, 1'b1, 2'd1, 1'b0);
    frame(20, 12'h456, 12'h456, 1'b0, 2'd2, 1'b0);
    frame(1,  12'h999, 12'h999, 1'b0, 2'd3, 1'b0);
    frame(0,  12'h000, 12'hFFF, 1'b1, 2'd2, 1'b0);
    frame(10, 12'h042, 12'h042, 1'b0, 2'd1, 1'b0);
    frame(19, 12'h300, 12'h300, 1'b0, 2'd0, 1'b0);
    frame(2,  12'h150, 12'h150, 1'b0, 2'd1, 1'b0);

    @(posedge clk); #1;
    chk("giro_after_proximo", estado, 1);
    ligar = 1'b0;
    @(posedge clk); #1;
    chk("giro_abort_idle", estado, 0);
    mc = medir_cnt;
    repeat (20) @(posedge clk);
    #1 chk("no_medir_when_off", medir_cnt, mc);

    ligar = 1'b1;
    frame(3, 12'h777, 12'h777, 1'b0, 2'd2, 1'b1);
    chk("espera_tx_drop_proximo", estado, 6);
    @(posedge clk); #1;
    chk("espera_tx_drop_idle", estado, 0);
    chk("posicao_end", posicao, 3);

    ligar = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ligar = 1'b0;
    chk("midrst_estado", estado, 0);
    chk("midrst_posicao", posicao, 0);
    chk("midrst_tx_medida", tx_medida, 0);
    chk("midrst_fim", fim, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("txq_drained", txq.size(), 0);
    chk("fimq_drained", fimq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
